// File: rtl/expr_alu_pipe.sv
// expr_alu_pipe
// Two-stage pipelined expression unit implementing the Verilog operator set
// on WIDTH-bit operands, with valid/ready flow control, an accumulator chain
// mode, status flags and per-transaction sequence tags.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready request handshake; accepted when both are high
//   in_op             5-bit opcode (29-31 illegal)
//   in_chain          use the accumulator in place of in_a
//   in_a, in_b        operands (in_b is also the shift amount)
//   out_valid/out_ready result handshake; consumed when both are high
//   out_result        WIDTH-bit result
//   out_carry         ADD carry-out / SUB borrow, 0 for other ops
//   out_zero          out_result == 0
//   out_err           illegal opcode
//   out_seq           sequence tag of this result
module expr_alu_pipe #(
  parameter int WIDTH      = 8,
  parameter bit SIGNED_CMP = 1'b0,
  parameter int SEQ_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic             in_chain,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_err,
  output logic [SEQ_W-1:0] out_seq
);

  localparam int HALF = WIDTH / 2;
  localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

  typedef enum logic [4:0] {
    OP_AND   = 5'd0,  OP_OR    = 5'd1,  OP_XOR   = 5'd2,  OP_XNOR  = 5'd3,
    OP_LAND  = 5'd4,  OP_LOR   = 5'd5,  OP_EQ    = 5'd6,  OP_NEQ   = 5'd7,
    OP_LT    = 5'd8,  OP_GT    = 5'd9,  OP_LEQ   = 5'd10, OP_GEQ   = 5'd11,
    OP_SLL   = 5'd12, OP_SRL   = 5'd13, OP_SLA   = 5'd14, OP_SRA   = 5'd15,
    OP_ADD   = 5'd16, OP_SUB   = 5'd17, OP_NEG   = 5'd18, OP_LNOT  = 5'd19,
    OP_INV   = 5'd20, OP_RAND  = 5'd21, OP_ROR   = 5'd22, OP_RXOR  = 5'd23,
    OP_RNAND = 5'd24, OP_RNOR  = 5'd25, OP_RXNOR = 5'd26, OP_CAT   = 5'd27,
    OP_REP   = 5'd28
  } op_e;

  // Zero-extends a single-bit result to the datapath width.
  function automatic logic [WIDTH-1:0] zext(input logic b);
    zext = {{(WIDTH-1){1'b0}}, b};
  endfunction

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_result;
  logic             r_s1_carry;
  logic             r_s1_zero;
  logic             r_s1_err;
  logic [SEQ_W-1:0] r_s1_seq;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic             r_out_carry;
  logic             r_out_zero;
  logic             r_out_err;
  logic [SEQ_W-1:0] r_out_seq;

  logic [WIDTH-1:0] r_acc;
  logic [SEQ_W-1:0] r_seq;

  logic             w_accept;
  logic             w_s2_free;
  logic             w_s2_load;
  logic [WIDTH-1:0] w_a;
  logic             w_shift_big;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_lt;
  logic             w_gt;
  logic [WIDTH-1:0] w_sra;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_err;

  // S2 can take a new entry when empty or when its current entry leaves this cycle.
  assign w_s2_free = !r_out_valid || out_ready;
  assign w_s2_load = r_s1_valid && w_s2_free;
  assign in_ready  = !r_s1_valid || w_s2_free;
  assign w_accept  = in_valid && in_ready;

  // The accumulator is read combinationally so a chained op issued right
  // after its producer sees the value written at the producer's accept edge.
  assign w_a         = in_chain ? r_acc : in_a;
  assign w_shift_big = (in_b >= SHIFT_LIM);
  assign w_sum       = {1'b0, w_a} + {1'b0, in_b};
  assign w_diff      = {1'b0, w_a} - {1'b0, in_b};
  assign w_lt        = SIGNED_CMP ? ($signed(w_a) < $signed(in_b)) : (w_a < in_b);
  assign w_gt        = SIGNED_CMP ? ($signed(w_a) > $signed(in_b)) : (w_a > in_b);
  // SRA sign-fills regardless of the compare mode.
  assign w_sra       = w_shift_big ? {WIDTH{w_a[WIDTH-1]}}
                                   : WIDTH'($signed(w_a) >>> in_b);

  always_comb begin
    w_result = '0;
    w_carry  = 1'b0;
    w_err    = 1'b0;
    case (in_op)
      OP_AND:   w_result = w_a & in_b;
      OP_OR:    w_result = w_a | in_b;
      OP_XOR:   w_result = w_a ^ in_b;
      OP_XNOR:  w_result = ~(w_a ^ in_b);
      OP_LAND:  w_result = zext((|w_a) && (|in_b));
      OP_LOR:   w_result = zext((|w_a) || (|in_b));
      OP_EQ:    w_result = zext(w_a == in_b);
      OP_NEQ:   w_result = zext(w_a != in_b);
      OP_LT:    w_result = zext(w_lt);
      OP_GT:    w_result = zext(w_gt);
      OP_LEQ:   w_result = zext(!w_gt);
      OP_GEQ:   w_result = zext(!w_lt);
      OP_SLL,
      OP_SLA:   w_result = w_shift_big ? '0 : (w_a << in_b);
      OP_SRL:   w_result = w_shift_big ? '0 : (w_a >> in_b);
      OP_SRA:   w_result = w_sra;
      OP_ADD: begin
        w_result = w_sum[WIDTH-1:0];
        w_carry  = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_result = w_diff[WIDTH-1:0];
        w_carry  = w_diff[WIDTH];
      end
      OP_NEG:   w_result = '0 - w_a;
      OP_LNOT:  w_result = zext(w_a == '0);
      OP_INV:   w_result = ~w_a;
      OP_RAND:  w_result = zext(&w_a);
      OP_ROR:   w_result = zext(|w_a);
      OP_RXOR:  w_result = zext(^w_a);
      OP_RNAND: w_result = zext(~&w_a);
      OP_RNOR:  w_result = zext(~|w_a);
      OP_RXNOR: w_result = zext(~^w_a);
      OP_CAT:   w_result = {w_a[HALF-1:0], in_b[HALF-1:0]};
      OP_REP:   w_result = {2{w_a[HALF-1:0]}};
      default:  w_err    = 1'b1;
    endcase
  end

  // Stage 1 plus architectural state (accumulator and tag counter).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_result <= '0;
      r_s1_carry  <= 1'b0;
      r_s1_zero   <= 1'b0;
      r_s1_err    <= 1'b0;
      r_s1_seq    <= '0;
      r_acc       <= '0;
      r_seq       <= '0;
    end else if (w_accept) begin
      r_s1_valid  <= 1'b1;
      r_s1_result <= w_result;
      r_s1_carry  <= w_carry;
      r_s1_zero   <= (w_result == '0);
      r_s1_err    <= w_err;
      r_s1_seq    <= r_seq;
      r_acc       <= w_result;
      r_seq       <= r_seq + SEQ_W'(1);
    end else if (w_s2_load) begin
      r_s1_valid  <= 1'b0;
    end
  end

  // Stage 2 output register; payload holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_carry  <= 1'b0;
      r_out_zero   <= 1'b0;
      r_out_err    <= 1'b0;
      r_out_seq    <= '0;
    end else if (w_s2_load) begin
      r_out_valid  <= 1'b1;
      r_out_result <= r_s1_result;
      r_out_carry  <= r_s1_carry;
      r_out_zero   <= r_s1_zero;
      r_out_err    <= r_s1_err;
      r_out_seq    <= r_s1_seq;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_carry  = r_out_carry;
  assign out_zero   = r_out_zero;
  assign out_err    = r_out_err;
  assign out_seq    = r_out_seq;

endmodule
